// File: rtl/rx_ctrl_pkg.sv
// Shared types and constants for the UART receive controller.
package rx_ctrl_pkg;

   typedef enum logic [1:0] {
      StRsync   = 2'd0,
      StIdle    = 2'd1,
      StAck     = 2'd2,
      StWaitClr = 2'd3
   } state_e;

   // Bit positions inside the 3-bit error field {overrun, parity, framing}
   localparam int unsigned ERR_FRAME   = 0;
   localparam int unsigned ERR_PARITY  = 1;
   localparam int unsigned ERR_OVERRUN = 2;

   localparam int unsigned LetterW = 8;
   localparam int unsigned ErrW    = 3;
   localparam int unsigned EntryW  = LetterW + ErrW;

   typedef struct packed {
      logic baudr;
      logic ps;
      logic dlr;
   } cfg_t;

   localparam cfg_t CfgDefault = '{baudr: 1'b0, ps: 1'b0, dlr: 1'b1};

endpackage

// File: rtl/rx_ctrl_fifo.sv
// Synchronous FIFO with registered occupancy; pointers wrap modulo DEPTH (power of two).
module rx_ctrl_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = 3,
   parameter int unsigned WIDTH = 11
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             empty_o,
   output logic             full_o,
   output logic [AW:0]      level_o
);

   localparam int unsigned LW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [AW:0]      level_q, level_d;
   logic             do_push, do_pop;

   assign empty_o = (level_q == '0);
   assign full_o  = (level_q == LW'(DEPTH));
   assign level_o = level_q;
   assign rdata_o = mem_q[rptr_q];

   // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      if (do_push) begin
         wptr_d = wptr_q + AW'(1);
      end
      if (do_pop) begin
         rptr_d = rptr_q + AW'(1);
      end
      unique case ({do_push, do_pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/rx_ctrl.sv
// UART receiver sequencer: acks letters, buffers them with error flags, owns receiver config.
// Optional saturating error counter enabled by defining RX_CTRL_ERR_CNT_EN.
module rx_ctrl
   import rx_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned AW      = 3,
   parameter int unsigned RST_CYC = 2,
   parameter int unsigned ACK_TO  = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [7:0]    rx_letter,
   input  logic          rx_valid,
   input  logic          rx_framee,
   input  logic          rx_paritye,
   input  logic          rx_overrune,
   output logic          rx_readen,
   output logic          rx_reset,
   output logic          rx_baudr,
   output logic          rx_ps,
   output logic          rx_dlr,
   input  logic          cfg_wr,
   input  logic          cfg_baudr,
   input  logic          cfg_ps,
   input  logic          cfg_dlr,
   output logic [7:0]    out_data,
   output logic [2:0]    out_err,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW:0]   fifo_level,
   output logic [7:0]    drop_cnt,
   output logic [15:0]   err_cnt
);

   localparam int unsigned MaxCyc = (RST_CYC > ACK_TO) ? RST_CYC : ACK_TO;
   localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

   state_e             state_q, state_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   cfg_t               cfg_q, cfg_d;
   cfg_t               shadow_q, shadow_d;
   logic               pend_q, pend_d;
   logic               ovr_q;
   logic [7:0]         drop_q, drop_d;
   logic               push, drop_inc;
   logic [ErrW-1:0]    push_err;
   logic [EntryW-1:0]  fifo_rdata;
   logic               fifo_empty, fifo_full;

   always_comb begin
      push_err              = '0;
      push_err[ERR_FRAME]   = rx_framee;
      push_err[ERR_PARITY]  = rx_paritye;
      push_err[ERR_OVERRUN] = rx_overrune;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cfg_d    = cfg_q;
      shadow_d = shadow_q;
      pend_d   = pend_q;
      push     = 1'b0;
      drop_inc = 1'b0;
      unique case (state_q)
         StRsync: begin
            if (cnt_q == CntW'(RST_CYC - 1)) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StIdle: begin
            if (pend_q) begin
               cfg_d   = shadow_q;
               pend_d  = 1'b0;
               state_d = StRsync;
               cnt_d   = '0;
            end else if (rx_valid) begin
               if (!fifo_full) begin
                  push    = 1'b1;
                  state_d = StAck;
               end else if (rx_overrune && !ovr_q) begin
                  // Letter stays held in the receiver; each overrun edge marks one lost letter
                  drop_inc = 1'b1;
               end
            end
         end
         StAck: begin
            state_d = StWaitClr;
            cnt_d   = '0;
         end
         StWaitClr: begin
            if (!rx_valid) begin
               state_d = StIdle;
            end else if (cnt_q == CntW'(ACK_TO - 1)) begin
               state_d = StAck;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: begin
            state_d = StRsync;
            cnt_d   = '0;
         end
      endcase
      // A write landing in the same cycle as an apply stays pending for the next safe point
      if (cfg_wr) begin
         shadow_d = '{baudr: cfg_baudr, ps: cfg_ps, dlr: cfg_dlr};
         pend_d   = 1'b1;
      end
   end

   always_comb begin
      drop_d = drop_q;
      if (drop_inc && (drop_q != 8'hFF)) begin
         drop_d = drop_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StRsync;
         cnt_q    <= '0;
         cfg_q    <= CfgDefault;
         shadow_q <= CfgDefault;
         pend_q   <= 1'b0;
         ovr_q    <= 1'b0;
         drop_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cfg_q    <= cfg_d;
         shadow_q <= shadow_d;
         pend_q   <= pend_d;
         ovr_q    <= rx_overrune;
         drop_q   <= drop_d;
      end
   end

   rx_ctrl_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .WIDTH (EntryW)
   ) u_fifo (
      .clk_i   (clk),
      .reset_i (reset),
      .push_i  (push),
      .wdata_i ({push_err, rx_letter}),
      .pop_i   (out_valid && out_ready),
      .rdata_o (fifo_rdata),
      .empty_o (fifo_empty),
      .full_o  (fifo_full),
      .level_o (fifo_level)
   );

   assign rx_readen = (state_q == StAck);
   assign rx_reset  = reset || (state_q == StRsync);
   assign rx_baudr  = cfg_q.baudr;
   assign rx_ps     = cfg_q.ps;
   assign rx_dlr    = cfg_q.dlr;
   assign out_valid = !fifo_empty;
   assign out_data  = fifo_rdata[LetterW-1:0];
   assign out_err   = fifo_rdata[EntryW-1:LetterW];
   assign drop_cnt  = drop_q;

`ifdef RX_CTRL_ERR_CNT_EN
   logic [15:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (push && (push_err != '0) && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_cnt = err_cnt_q;
`else
   assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_rx_ctrl.sv
// Scoreboard bench for rx_ctrl: receiver model drives letters, monitor checks the output stream.
module tb_rx_ctrl;

   localparam int unsigned DEPTH   = 8;
   localparam int unsigned AW      = 3;
   localparam int unsigned RST_CYC = 2;
   localparam int unsigned ACK_TO  = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [7:0]    rx_letter;
   logic          rx_valid, rx_framee, rx_paritye, rx_overrune;
   logic          rx_readen, rx_reset, rx_baudr, rx_ps, rx_dlr;
   logic          cfg_wr, cfg_baudr, cfg_ps, cfg_dlr;
   logic [7:0]    out_data;
   logic [2:0]    out_err;
   logic          out_valid, out_ready;
   logic [AW:0]   fifo_level;
   logic [7:0]    drop_cnt;
   logic [15:0]   err_cnt;

   int            n_chk = 0;
   int            n_fail = 0;
   int            err_exp = 0;
   logic [10:0]   exp_q[$];

   logic          readen_prev = 1'b0;
   logic          hold_prev = 1'b0;
   logic [10:0]   data_prev = '0;
   logic [10:0]   mon_e;

   always #5 clk = ~clk;

   rx_ctrl #(
      .DEPTH   (DEPTH),
      .AW      (AW),
      .RST_CYC (RST_CYC),
      .ACK_TO  (ACK_TO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rx_letter   (rx_letter),
      .rx_valid    (rx_valid),
      .rx_framee   (rx_framee),
      .rx_paritye  (rx_paritye),
      .rx_overrune (rx_overrune),
      .rx_readen   (rx_readen),
      .rx_reset    (rx_reset),
      .rx_baudr    (rx_baudr),
      .rx_ps       (rx_ps),
      .rx_dlr      (rx_dlr),
      .cfg_wr      (cfg_wr),
      .cfg_baudr   (cfg_baudr),
      .cfg_ps      (cfg_ps),
      .cfg_dlr     (cfg_dlr),
      .out_data    (out_data),
      .out_err     (out_err),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .fifo_level  (fifo_level),
      .drop_cnt    (drop_cnt),
      .err_cnt     (err_cnt)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_ack(input string nm, input bit rnd);
      int n = 0;
      do begin
         cyc(1);
         if (rnd) out_ready = 1'($urandom_range(0, 1));
         n++;
      end while (!rx_readen && n < 200);
      chk(nm, rx_readen, 1'b1);
   endtask

   // Receiver model: present a letter, hold it until acknowledged, then go quiet for a while
   task automatic send(input logic [7:0] l, input logic [2:0] e, input int hold, input bit rnd);
      exp_q.push_back({e, l});
      if (e != 3'b000) err_exp++;
      rx_letter = l;
      {rx_overrune, rx_paritye, rx_framee} = e;
      rx_valid = 1'b1;
      wait_ack("send_ack", rnd);
      repeat (hold) begin
         cyc(1);
         if (rnd) out_ready = 1'($urandom_range(0, 1));
      end
      rx_valid = 1'b0;
      {rx_overrune, rx_paritye, rx_framee} = 3'b000;
      cyc(2);
   endtask

   task automatic drain();
      int n = 0;
      out_ready = 1'b1;
      while (fifo_level != '0 && n < 100) begin
         cyc(1);
         n++;
      end
      cyc(1);
      chk("drain_level", 32'(fifo_level), 0);
      chk("scoreboard_empty", exp_q.size(), 0);
      out_ready = 1'b0;
   endtask

   // Monitor: pops the scoreboard on every stream handshake, checks hold and ack spacing
   always @(negedge clk) begin
      if (!reset) begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL scoreboard_underflow: got 0x%0h, expected no entry", {out_err, out_data});
            end else begin
               mon_e = exp_q.pop_front();
               chk("stream_data", 32'(out_data), 32'(mon_e[7:0]));
               chk("stream_err", 32'(out_err), 32'(mon_e[10:8]));
            end
         end
         if (hold_prev) begin
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_data", 32'({out_err, out_data}), 32'(data_prev));
         end
         if (rx_readen) chk("readen_spacing", readen_prev, 1'b0);
         hold_prev   = out_valid && !out_ready;
         data_prev   = {out_err, out_data};
         readen_prev = rx_readen;
      end else begin
         hold_prev   = 1'b0;
         readen_prev = 1'b0;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, k, acks;
      logic [2:0] e;
      reset = 1'b1;
      rx_letter = '0;
      {rx_valid, rx_framee, rx_paritye, rx_overrune} = '0;
      {cfg_wr, cfg_baudr, cfg_ps, cfg_dlr} = '0;
      out_ready = 1'b0;
      cyc(3);
      reset = 1'b0;

      // Reset release
      chk("rst_rx_reset_c0", rx_reset, 1'b1);
      chk("rst_baudr", rx_baudr, 1'b0);
      chk("rst_ps", rx_ps, 1'b0);
      chk("rst_dlr", rx_dlr, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_level", 32'(fifo_level), 0);
      chk("rst_drop", 32'(drop_cnt), 0);
      chk("rst_err_cnt", 32'(err_cnt), 0);
      chk("rst_readen", rx_readen, 1'b0);
      cyc(1);
      chk("rst_rx_reset_c1", rx_reset, 1'b1);
      cyc(1);
      chk("rst_rx_reset_c2", rx_reset, 1'b0);

      // Single clean letter
      send(8'h41, 3'b000, 0, 1'b0);
      chk("single_readen_drop", rx_readen, 1'b0);
      chk("single_valid", out_valid, 1'b1);
      chk("single_data", 32'(out_data), 32'h41);
      chk("single_err", 32'(out_err), 0);
      chk("single_level", 32'(fifo_level), 1);
      drain();

      // Fill FIFO, then hold a ninth letter with overrun edges
      for (int i = 0; i < DEPTH; i++) send(8'(8'h10 + i), 3'b000, 0, 1'b0);
      chk("full_level", 32'(fifo_level), DEPTH);
      exp_q.push_back({3'b100, 8'h99});
      err_exp++;
      rx_letter = 8'h99;
      rx_valid  = 1'b1;
      acks = 0;
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         if (rx_readen) acks++;
      end
      chk("full_no_ack", acks, 0);
      rx_overrune = 1'b1;
      cyc(3);
      chk("drop_first", 32'(drop_cnt), 1);
      rx_overrune = 1'b0;
      cyc(1);
      rx_overrune = 1'b1;
      cyc(3);
      chk("drop_second", 32'(drop_cnt), 2);
      cyc(5);
      chk("drop_held_level", 32'(drop_cnt), 2);
      chk("full_level_held", 32'(fifo_level), DEPTH);
      out_ready = 1'b1;
      cyc(1);
      out_ready = 1'b0;
      wait_ack("ninth_ack", 1'b0);
      rx_valid = 1'b0;
      rx_overrune = 1'b0;
      cyc(2);
      chk("ninth_level", 32'(fifo_level), DEPTH);
      drain();

      // Re-pulse when valid stays high
      out_ready = 1'b1;
      exp_q.push_back({3'b000, 8'h5A});
      rx_letter = 8'h5A;
      rx_valid  = 1'b1;
      wait_ack("repulse_first", 1'b0);
      n = 0;
      do begin
         cyc(1);
         n++;
      end while (!rx_readen && n < 20);
      chk("repulse_gap", n, ACK_TO + 1);
      rx_valid = 1'b0;
      cyc(1);
      chk("repulse_single", rx_readen, 1'b0);
      cyc(1);
      drain();

      // Config write during WAIT_CLR applies only from IDLE
      out_ready = 1'b1;
      exp_q.push_back({3'b000, 8'hC3});
      rx_letter = 8'hC3;
      rx_valid  = 1'b1;
      wait_ack("cfg_ack", 1'b0);
      cyc(1);
      {cfg_baudr, cfg_ps, cfg_dlr} = 3'b101;
      cfg_wr = 1'b1;
      cyc(1);
      cfg_wr = 1'b0;
      chk("cfg_hold_waitclr", rx_baudr, 1'b0);
      rx_valid = 1'b0;
      cyc(1);
      chk("cfg_hold_idle", rx_baudr, 1'b0);
      n = 0;
      while (!rx_baudr && n < 10) begin
         cyc(1);
         n++;
      end
      chk("cfg_apply_lat", n, 1);
      chk("cfg_apply", rx_baudr, 1'b1);
      k = 0;
      while (rx_reset && k < 10) begin
         cyc(1);
         k++;
      end
      chk("cfg_rst_len", k, RST_CYC);
      drain();

      // Last write wins
      {cfg_baudr, cfg_ps, cfg_dlr} = 3'b100;
      cfg_wr = 1'b1;
      cyc(1);
      {cfg_baudr, cfg_ps, cfg_dlr} = 3'b010;
      cyc(1);
      cfg_wr = 1'b0;
      cyc(12);
      chk("lww_baudr", rx_baudr, 1'b0);
      chk("lww_ps", rx_ps, 1'b1);
      chk("lww_dlr", rx_dlr, 1'b0);
      chk("lww_rx_reset", rx_reset, 1'b0);

      // Directed parity-error letters
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) send(8'(8'hE0 + i), 3'b010, 0, 1'b0);
      drain();

      // Random traffic with random backpressure
      for (int i = 0; i < 60; i++) begin
         e = 3'($urandom_range(0, 3));
         send(8'($urandom_range(0, 255)), e, $urandom_range(0, 2), 1'b1);
      end
      drain();
`ifdef RX_CTRL_ERR_CNT_EN
      chk("err_cnt", 32'(err_cnt), 32'(err_exp));
`else
      chk("err_cnt_off", 32'(err_cnt), 0);
`endif
      chk("drop_final", 32'(drop_cnt), 2);

      // Reset mid-traffic flushes everything
      for (int i = 0; i < 3; i++) send(8'(8'h70 + i), 3'b001, 0, 1'b0);
      chk("pre_reset_level", 32'(fifo_level), 3);
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      exp_q.delete();
      err_exp = 0;
      chk("flush_level", 32'(fifo_level), 0);
      chk("flush_valid", out_valid, 1'b0);
      chk("flush_drop", 32'(drop_cnt), 0);
      chk("flush_err_cnt", 32'(err_cnt), 0);
      chk("flush_baudr", rx_baudr, 1'b0);
      chk("flush_ps", rx_ps, 1'b0);
      chk("flush_dlr", rx_dlr, 1'b1);
      chk("flush_rx_reset", rx_reset, 1'b1);
      cyc(RST_CYC);
      chk("flush_rx_reset_end", rx_reset, 1'b0);
      send(8'h7E, 3'b000, 0, 1'b0);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
